// File: rtl/regfile_writeback.sv
// Writeback stage: merges never-stalling ALU results with queued, aligned load responses
// onto one register-file write port. Define WB_PARTIAL_MERGE_EN for byte-masked merge loads.
module regfile_writeback #(
  parameter int LQ_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        ALU_VALID,
  input  logic [4:0]  ALU_RD,
  input  logic [63:0] ALU_DATA,
  input  logic        LD_VALID,
  output logic        LD_READY,
  input  logic [4:0]  LD_RD,
  input  logic [63:0] LD_DATA,
  input  logic [1:0]  LD_SIZE,
  input  logic [2:0]  LD_OFFSET,
  input  logic        LD_SIGNED,
  input  logic        LD_MERGE,
  output logic        RegWrite,
  output logic [4:0]  W_ADDR,
  output logic [63:0] W_DATA,
  output logic [7:0]  W_MASK,
  output logic [31:0] PENDING,
  output logic        MISALIGN
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [7:0]  mask;
  } lq_entry_t;

  lq_entry_t           lq_mem [LQ_DEPTH];
  logic [LQ_DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]       head_q, tail_q;
  logic [CW-1:0]       count_q, count_d;
  logic [31:0]         pending_d;

  logic      alu_wr, ld_fire, misaligned, ld_keep, ld_killed;
  logic      q_empty, pop, bypass, push;
  logic [63:0] shifted;
  lq_entry_t ld_entry;

`ifdef WB_PARTIAL_MERGE_EN
  logic [7:0] lane_mask;
`else
  logic unused_merge;
  assign unused_merge = LD_MERGE;
`endif

  // Alignment happens before enqueue so every entry is a ready-to-write result.
  // NOTE: every always_comb target gets a default first so no latch can be inferred.
  always_comb begin
    shifted       = LD_DATA >> {LD_OFFSET, 3'b000};
    ld_entry.rd   = LD_RD;
    ld_entry.mask = 8'hFF;
    ld_entry.data = shifted;
    case (LD_SIZE)
      2'd0:    ld_entry.data = {{56{LD_SIGNED & shifted[7]}},  shifted[7:0]};
      2'd1:    ld_entry.data = {{48{LD_SIGNED & shifted[15]}}, shifted[15:0]};
      2'd2:    ld_entry.data = {{32{LD_SIGNED & shifted[31]}}, shifted[31:0]};
      default: ld_entry.data = shifted;
    endcase
`ifdef WB_PARTIAL_MERGE_EN
    case (LD_SIZE)
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h03;
      2'd2:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
    if (LD_MERGE) begin
      ld_entry.data = LD_DATA;
      ld_entry.mask = lane_mask << LD_OFFSET;
    end
`endif
  end

  // (1<<size)-1 in three bits wraps to 7 for a doubleword, which is the mask we want.
  assign misaligned = |(LD_OFFSET & ((3'd1 << LD_SIZE) - 3'd1));
  assign alu_wr     = ALU_VALID && (ALU_RD != 5'd0);
  assign ld_fire    = LD_VALID && LD_READY;
  assign ld_keep    = ld_fire && !misaligned && (LD_RD != 5'd0);
  assign ld_killed  = alu_wr && (LD_RD == ALU_RD);
  assign q_empty    = (count_q == '0);
  assign pop        = !alu_wr && !q_empty;
  assign bypass     = !alu_wr && q_empty && ld_keep;
  assign push       = ld_keep && !bypass;
  assign count_d    = count_q + CW'(push) - CW'(pop);

  // A killed entry keeps its slot until it reaches the head, but stops counting as pending.
  always_comb begin
    live_d    = live_q;
    pending_d = '0;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (alu_wr && (lq_mem[i].rd == ALU_RD)) live_d[i] = 1'b0;
    if (pop)  live_d[head_q] = 1'b0;
    if (push) live_d[tail_q] = !ld_killed;
    for (int i = 0; i < LQ_DEPTH; i++)
      if (live_d[i])
        pending_d[(push && (PW'(i) == tail_q)) ? LD_RD : lq_mem[i].rd] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      live_q   <= '0;
      LD_READY <= 1'b0;
      RegWrite <= 1'b0;
      W_ADDR   <= '0;
      W_DATA   <= '0;
      W_MASK   <= '0;
      PENDING  <= '0;
      MISALIGN <= 1'b0;
    end else begin
      if (pop)  head_q <= head_q + PW'(1);
      if (push) tail_q <= tail_q + PW'(1);
      count_q  <= count_d;
      live_q   <= live_d;
      LD_READY <= (count_d != CW'(LQ_DEPTH));
      PENDING  <= pending_d;
      MISALIGN <= ld_fire && misaligned;
      RegWrite <= 1'b0;
      if (alu_wr) begin
        RegWrite <= 1'b1;
        W_ADDR   <= ALU_RD;
        W_DATA   <= ALU_DATA;
        W_MASK   <= 8'hFF;
      end else if (pop) begin
        RegWrite                 <= live_q[head_q];
        {W_ADDR, W_DATA, W_MASK} <= lq_mem[head_q];
      end else if (bypass) begin
        RegWrite                 <= 1'b1;
        {W_ADDR, W_DATA, W_MASK} <= ld_entry;
      end
    end
  end

  // NOTE: queue storage has no reset; live_q and count_q alone decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) lq_mem[tail_q] <= ld_entry;
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, ALU path, load alignment, queueing, kill and merge.
module tb_regfile_writeback;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ALU_VALID, LD_VALID, LD_SIGNED, LD_MERGE;
  logic [4:0]  ALU_RD, LD_RD;
  logic [63:0] ALU_DATA, LD_DATA;
  logic [1:0]  LD_SIZE;
  logic [2:0]  LD_OFFSET;
  logic        LD_READY, RegWrite, MISALIGN;
  logic [4:0]  W_ADDR;
  logic [63:0] W_DATA;
  logic [7:0]  W_MASK;
  logic [31:0] PENDING;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [63:0] D = 64'h1122_3344_5566_8899;

  regfile_writeback #(.LQ_DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
    .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_RD(LD_RD), .LD_DATA(LD_DATA),
    .LD_SIZE(LD_SIZE), .LD_OFFSET(LD_OFFSET), .LD_SIGNED(LD_SIGNED), .LD_MERGE(LD_MERGE),
    .RegWrite(RegWrite), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_MASK(W_MASK),
    .PENDING(PENDING), .MISALIGN(MISALIGN)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ALU_VALID = 0; ALU_RD = 0; ALU_DATA = 0;
    LD_VALID = 0; LD_RD = 0; LD_DATA = 0; LD_SIZE = 0; LD_OFFSET = 0;
    LD_SIGNED = 0; LD_MERGE = 0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [63:0] data, input logic [1:0] size,
                          input logic [2:0] off, input logic sgn, input logic merge);
    LD_VALID = 1; LD_RD = rd; LD_DATA = data; LD_SIZE = size; LD_OFFSET = off;
    LD_SIGNED = sgn; LD_MERGE = merge;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [63:0] data);
    ALU_VALID = 1; ALU_RD = rd; ALU_DATA = data;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_N = 0;
    step(); step();
    n_cmp++;
    if ({RegWrite, W_ADDR, W_DATA, W_MASK, PENDING, MISALIGN, LD_READY} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got we=%0b addr=%0d data=%h mask=%h pend=%h mis=%0b rdy=%0b, want all 0",
               RegWrite, W_ADDR, W_DATA, W_MASK, PENDING, MISALIGN, LD_READY);
    end
    RST_N = 1;
    step();
    n_cmp++;
    if ({LD_READY, RegWrite} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_release: got rdy=%0b we=%0b, want rdy=1 we=0", LD_READY, RegWrite);
    end
  endtask

  task automatic test_alu();
    set_alu(5'd5, 64'h0123_4567_89AB_CDEF);
    step();
    ALU_VALID = 0;
    n_cmp++;
    if ({RegWrite, W_ADDR, W_DATA, W_MASK} !== {1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 8'hFF}) begin
      n_bad++;
      $display("FAIL alu_write: got we=%0b addr=%0d data=%h mask=%h, want 1/5/0123456789abcdef/ff",
               RegWrite, W_ADDR, W_DATA, W_MASK);
    end
    step();
    n_cmp++;
    if (RegWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL alu_single_cycle: got we=%0b want 0", RegWrite);
    end
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [1:0]  size;
    logic [2:0]  off;
    logic        sgn;
    logic [63:0] exp;
  } ld_vec_t;

  task automatic test_load_extend();
    ld_vec_t v [8];
    v[0] = '{5'd7,  D, 2'd0, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF99};
    v[1] = '{5'd7,  D, 2'd0, 3'd0, 1'b0, 64'h0000_0000_0000_0099};
    v[2] = '{5'd8,  D, 2'd1, 3'd2, 1'b0, 64'h0000_0000_0000_5566};
    v[3] = '{5'd9,  D, 2'd1, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_8899};
    v[4] = '{5'd10, D, 2'd2, 3'd4, 1'b1, 64'h0000_0000_1122_3344};
    v[5] = '{5'd11, D, 2'd3, 3'd0, 1'b1, D};
    v[6] = '{5'd12, D, 2'd0, 3'd7, 1'b1, 64'h0000_0000_0000_0011};
    v[7] = '{5'd13, 64'h0000_0000_8000_0001, 2'd2, 3'd0, 1'b1, 64'hFFFF_FFFF_8000_0001};
    for (int i = 0; i < 8; i++) begin
      set_load(v[i].rd, v[i].data, v[i].size, v[i].off, v[i].sgn, 1'b0);
      step();
      LD_VALID = 0;
      n_cmp++;
      if ({RegWrite, W_ADDR, W_DATA, W_MASK, PENDING} !== {1'b1, v[i].rd, v[i].exp, 8'hFF, 32'h0}) begin
        n_bad++;
        $display("FAIL load_extend[%0d]: got we=%0b addr=%0d data=%h mask=%h pend=%h, want 1/%0d/%h/ff/0",
                 i, RegWrite, W_ADDR, W_DATA, W_MASK, PENDING, v[i].rd, v[i].exp);
      end
    end
    step();
  endtask

  task automatic test_misalign();
    logic [1:0] sz [3];
    logic [2:0] of [3];
    sz[0] = 2'd2; of[0] = 3'd2;
    sz[1] = 2'd1; of[1] = 3'd3;
    sz[2] = 2'd3; of[2] = 3'd4;
    for (int i = 0; i < 3; i++) begin
      set_load(5'd15, D, sz[i], of[i], 1'b0, 1'b0);
      step();
      LD_VALID = 0;
      n_cmp++;
      if ({MISALIGN, RegWrite, PENDING} !== {1'b1, 1'b0, 32'h0}) begin
        n_bad++;
        $display("FAIL misalign_pulse[%0d]: got mis=%0b we=%0b pend=%h, want 1/0/0", i, MISALIGN, RegWrite, PENDING);
      end
      step();
      n_cmp++;
      if ({MISALIGN, RegWrite, PENDING, LD_READY} !== {1'b0, 1'b0, 32'h0, 1'b1}) begin
        n_bad++;
        $display("FAIL misalign_after[%0d]: got mis=%0b we=%0b pend=%h rdy=%0b, want 0/0/0/1",
                 i, MISALIGN, RegWrite, PENDING, LD_READY);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] exp_pend;
    for (int i = 0; i < 4; i++) begin
      set_alu(5'd1, 64'hA0 + 64'(i));
      set_load(5'(2 + i), 64'hD0 + 64'(i), 2'd3, 3'd0, 1'b0, 1'b0);
      step();
      n_cmp++;
      if ({RegWrite, W_ADDR, W_DATA} !== {1'b1, 5'd1, 64'hA0 + 64'(i)}) begin
        n_bad++;
        $display("FAIL fill_alu[%0d]: got we=%0b addr=%0d data=%h, want 1/1/%h", i, RegWrite, W_ADDR, W_DATA, 64'hA0 + 64'(i));
      end
    end
    LD_VALID = 0;
    n_cmp++;
    if ({LD_READY, PENDING} !== {1'b0, 32'h0000_003C}) begin
      n_bad++;
      $display("FAIL full_state: got rdy=%0b pend=%h, want 0/0000003c", LD_READY, PENDING);
    end
    set_load(5'd6, 64'hEE, 2'd3, 3'd0, 1'b0, 1'b0);
    step();
    LD_VALID = 0;
    ALU_VALID = 0;
    n_cmp++;
    if ({RegWrite, W_ADDR, LD_READY} !== {1'b1, 5'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL full_refuse: got we=%0b addr=%0d rdy=%0b, want 1/1/0", RegWrite, W_ADDR, LD_READY);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      exp_pend = 32'h0;
      for (int r = 3 + i; r <= 5; r++) exp_pend[r] = 1'b1;
      n_cmp++;
      if ({RegWrite, W_ADDR, W_DATA, W_MASK, PENDING, LD_READY} !==
          {1'b1, 5'(2 + i), 64'hD0 + 64'(i), 8'hFF, exp_pend, 1'b1}) begin
        n_bad++;
        $display("FAIL drain[%0d]: got we=%0b addr=%0d data=%h mask=%h pend=%h rdy=%0b, want 1/%0d/%h/ff/%h/1",
                 i, RegWrite, W_ADDR, W_DATA, W_MASK, PENDING, LD_READY, 2 + i, 64'hD0 + 64'(i), exp_pend);
      end
    end
    step();
    n_cmp++;
    if (RegWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_done: got we=%0b addr=%0d, want we=0", RegWrite, W_ADDR);
    end
  endtask

  task automatic test_kill();
    set_alu(5'd1, 64'h11);
    set_load(5'd9, 64'h99, 2'd3, 3'd0, 1'b0, 1'b0);
    step();
    LD_VALID = 0;
    n_cmp++;
    if (PENDING !== 32'h0000_0200) begin
      n_bad++;
      $display("FAIL kill_pending_set: got pend=%h want 00000200", PENDING);
    end
    set_alu(5'd9, 64'hBEEF);
    step();
    ALU_VALID = 0;
    n_cmp++;
    if ({RegWrite, W_ADDR, W_DATA, PENDING} !== {1'b1, 5'd9, 64'hBEEF, 32'h0}) begin
      n_bad++;
      $display("FAIL kill_alu: got we=%0b addr=%0d data=%h pend=%h, want 1/9/beef/0", RegWrite, W_ADDR, W_DATA, PENDING);
    end
    step();
    n_cmp++;
    if (RegWrite !== 1'b0) begin
      n_bad++;
      $display("FAIL kill_pop: got we=%0b addr=%0d data=%h, want we=0", RegWrite, W_ADDR, W_DATA);
    end
    set_alu(5'd10, 64'hCAFE);
    set_load(5'd10, 64'h77, 2'd3, 3'd0, 1'b0, 1'b0);
    step();
    LD_VALID = 0;
    ALU_VALID = 0;
    n_cmp++;
    if ({RegWrite, W_ADDR, W_DATA, PENDING} !== {1'b1, 5'd10, 64'hCAFE, 32'h0}) begin
      n_bad++;
      $display("FAIL kill_same_cycle: got we=%0b addr=%0d data=%h pend=%h, want 1/10/cafe/0", RegWrite, W_ADDR, W_DATA, PENDING);
    end
    step();
    step();
    n_cmp++;
    if ({RegWrite, LD_READY} !== 2'b01) begin
      n_bad++;
      $display("FAIL kill_same_cycle_after: got we=%0b rdy=%0b, want 0/1", RegWrite, LD_READY);
    end
  endtask

  task automatic test_rd0();
    set_alu(5'd1, 64'h1);
    set_load(5'd12, 64'h1212, 2'd3, 3'd0, 1'b0, 1'b0);
    step();
    LD_VALID = 0;
    set_alu(5'd0, 64'hDEAD);
    step();
    ALU_VALID = 0;
    n_cmp++;
    if ({RegWrite, W_ADDR, W_DATA} !== {1'b1, 5'd12, 64'h1212}) begin
      n_bad++;
      $display("FAIL alu_rd0_no_block: got we=%0b addr=%0d data=%h, want 1/12/1212", RegWrite, W_ADDR, W_DATA);
    end
    set_load(5'd0, 64'h55, 2'd3, 3'd0, 1'b0, 1'b0);
    step();
    LD_VALID = 0;
    n_cmp++;
    if ({RegWrite, PENDING} !== {1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL load_rd0: got we=%0b pend=%h, want 0/0", RegWrite, PENDING);
    end
  endtask

  task automatic test_back_to_back();
    set_load(5'd13, 64'hAAAA, 2'd3, 3'd0, 1'b0, 1'b0);
    step();
    n_cmp++;
    if ({RegWrite, W_ADDR, W_DATA} !== {1'b1, 5'd13, 64'hAAAA}) begin
      n_bad++;
      $display("FAIL b2b_first: got we=%0b addr=%0d data=%h, want 1/13/aaaa", RegWrite, W_ADDR, W_DATA);
    end
    set_load(5'd14, 64'hBBBB, 2'd3, 3'd0, 1'b0, 1'b0);
    step();
    LD_VALID = 0;
    n_cmp++;
    if ({RegWrite, W_ADDR, W_DATA, PENDING} !== {1'b1, 5'd14, 64'hBBBB, 32'h0}) begin
      n_bad++;
      $display("FAIL b2b_second: got we=%0b addr=%0d data=%h pend=%h, want 1/14/bbbb/0", RegWrite, W_ADDR, W_DATA, PENDING);
    end
    step();
  endtask

  task automatic test_reset_mid();
    set_alu(5'd1, 64'h1);
    set_load(5'd20, 64'h2020, 2'd3, 3'd0, 1'b0, 1'b0);
    step();
    idle_inputs();
    RST_N = 0;
    #1;
    n_cmp++;
    if ({RegWrite, PENDING, LD_READY} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got we=%0b pend=%h rdy=%0b, want 0/0/0", RegWrite, PENDING, LD_READY);
    end
    #2;
    RST_N = 1;
    step();
    step();
    n_cmp++;
    if ({RegWrite, PENDING, LD_READY} !== {1'b0, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_discard: got we=%0b addr=%0d pend=%h rdy=%0b, want 0/-/0/1", RegWrite, W_ADDR, PENDING, LD_READY);
    end
  endtask

  task automatic test_merge();
    set_load(5'd3, D, 2'd1, 3'd4, 1'b0, 1'b1);
    step();
    idle_inputs();
`ifdef WB_PARTIAL_MERGE_EN
    n_cmp++;
    if ({RegWrite, W_ADDR, W_DATA, W_MASK} !== {1'b1, 5'd3, D, 8'b0011_0000}) begin
      n_bad++;
      $display("FAIL merge: got we=%0b addr=%0d data=%h mask=%b, want 1/3/%h/00110000", RegWrite, W_ADDR, W_DATA, W_MASK, D);
    end
`else
    n_cmp++;
    if ({RegWrite, W_ADDR, W_DATA, W_MASK} !== {1'b1, 5'd3, 64'h3344, 8'hFF}) begin
      n_bad++;
      $display("FAIL merge_ignored: got we=%0b addr=%0d data=%h mask=%h, want 1/3/3344/ff", RegWrite, W_ADDR, W_DATA, W_MASK);
    end
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_extend();
    test_misalign();
    test_fill_drain();
    test_kill();
    test_rd0();
    test_back_to_back();
    test_merge();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writeback stage directly upstream of the 32x64 register file. Drives its RegWrite, W_ADDR, W_DATA and W_MASK inputs.
- Merges two result sources:
  - ALU results: one per cycle, never stallable, always highest priority.
  - Memory load responses: valid/ready handshake, buffered in a small FIFO.
- Load data is extracted from the 64-bit response, aligned, and sign- or zero-extended.

Parameters:
- LQ_DEPTH, 4, number of load-queue entries; power of 2, minimum 2.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ALU_VALID  in  1  ALU result valid this cycle.
- ALU_RD  in  [0:4]  ALU destination register.
- ALU_DATA  in  [0:63]  ALU result.
- LD_VALID  in  1  load response valid.
- LD_READY  out  1  queue can accept a load response.
- LD_RD  in  [0:4]  load destination register.
- LD_DATA  in  [0:63]  raw doubleword. Byte lane k = bits [8k+:8]; lane 0 is most significant.
- LD_SIZE  in  [0:1]  0=byte, 1=half, 2=word, 3=dword.
- LD_OFFSET  in  [0:2]  byte address within the doubleword. Address byte a maps to lane 7-a.
- LD_SIGNED  in  1  1=sign-extend, 0=zero-extend.
- LD_MERGE  in  1  partial-write request; used only with the optional feature.
- RegWrite  out  1  register-file write enable.
- W_ADDR  out  [0:4]  write address.
- W_DATA  out  [0:63]  write data.
- W_MASK  out  [0:7]  byte-lane enables.
- PENDING  out  [0:31]  PENDING[r]=1 while a queued load targets register r.
- MISALIGN  out  1  one-cycle pulse when a misaligned load is dropped.

Behaviour:
- Reset (RST_N=0, asynchronous): RegWrite=0, W_ADDR=0, W_DATA=0, W_MASK=0, PENDING=0, MISALIGN=0, queue emptied, LD_READY=0. After release, LD_READY=1 from the first clock edge.
- A reset mid-operation discards all queued loads. No writes are issued for them.
- All register-file outputs are registered. A winning result at cycle t appears on the outputs at t+1 for exactly one cycle.
- Load accept: a handshake occurs when LD_VALID & LD_READY at a clock edge. LD_READY = queue not full, registered; it does not depend on LD_VALID.
- Misaligned load: LD_OFFSET is not a multiple of (1<<LD_SIZE).
  - The load is accepted, but not queued.
  - MISALIGN=1 at t+1.
  - PENDING is unchanged.
- Alignment: nbytes = 1<<LD_SIZE. The source lanes are 8-LD_OFFSET-nbytes .. 7-LD_OFFSET. They are right-justified into lanes 8-nbytes..7. The upper lanes are filled with the sign bit (LD_SIGNED=1) or zero. W_MASK=8'hFF.
- Alignment is done at enqueue, so each queue entry holds a final rd, data and mask.
- Arbitration, evaluated each cycle:
  1. ALU_VALID & ALU_RD!=0: the ALU result is written with W_MASK=8'hFF.
  2. Otherwise, if the queue is non-empty, the head entry is written and popped.
  3. Otherwise, a load accepted this cycle while the queue is empty bypasses the queue. It is written at t+1 and never sets PENDING.
  4. Otherwise RegWrite=0.
- Destination register 0:
  - An ALU_RD=0 result is ignored and does not block the queue.
  - A load with rd=0 is accepted and discarded.
- Kill rule (write-after-write):
  - When an ALU write to rd=r is issued, every queued entry with rd=r is marked killed.
  - A killed entry pops without asserting RegWrite; that cycle's write slot stays unused.
  - The kill also applies to a load accepted in the same cycle with rd=r.
- PENDING[r] = OR over live (unkilled) queue entries with rd=r.
  - It is set the cycle after enqueue.
  - It is cleared the cycle after that entry's pop or kill, unless another live entry also targets r.
- Simultaneous push and pop at full: the pop frees a slot, but LD_READY is registered and does not rise until the next cycle.
- Queue pointers are log2(LQ_DEPTH) bits with wrap-around. A separate count of 0..LQ_DEPTH distinguishes full from empty.
- Starvation: with continuous ALU writes the queue never drains. This is by design; upstream uses PENDING to throttle.

Optional Feature:
- Macro: WB_PARTIAL_MERGE_EN.
- Defined, and LD_MERGE=1 on an aligned load:
  - No extension or shifting is done.
  - W_DATA = LD_DATA.
  - W_MASK has 1s only for source lanes 8-LD_OFFSET-nbytes .. 7-LD_OFFSET.
  - The register file merges the bytes in place.
- Defined, LD_MERGE=0: behaviour is as without the macro.
- Not defined: LD_MERGE is ignored, and all loads use extend mode with W_MASK=8'hFF.

Test Plan:
- Reset, then ALU_VALID=1, ALU_RD=5, ALU_DATA=64'h0123_4567_89AB_CDEF at t -> RegWrite=1, W_ADDR=5, W_DATA unchanged, W_MASK=8'hFF at t+1, then RegWrite=0.
- Load with LD_DATA=64'h1122_3344_5566_8899, LD_SIZE=0, LD_OFFSET=0, LD_SIGNED=1, rd=7, queue empty, ALU idle -> W_DATA=64'hFFFF_FFFF_FFFF_FF99 at t+1. Same load with LD_SIGNED=0 -> 64'h99.
- LD_SIZE=1, LD_OFFSET=2, same LD_DATA, zero-extend -> W_DATA=64'h5566. LD_SIZE=2, LD_OFFSET=2 -> MISALIGN=1 for one cycle, no write.
- Continuous ALU writes to rd=1 while pushing loads to rd=2,3,4,5 -> after 4 accepts LD_READY=0 and PENDING bits 2..5=1. Stop ALU -> four writes in FIFO order on consecutive cycles; PENDING returns to 0.
- Queue load rd=9, then ALU write rd=9 before drain -> only the ALU write appears; PENDING[9] clears; no later write to 9.
- With WB_PARTIAL_MERGE_EN: LD_MERGE=1, LD_SIZE=1, LD_OFFSET=4, rd=3 -> W_MASK=8'b0011_0000, W_DATA=LD_DATA.
